// File: rtl/frame_pointer_ctrl.sv
// frame_pointer_ctrl: frame-pointer controller for a windowed register file.
//
// Handles CALL/RTN requests from the decoder and drives the register file's
// window pointer. Each CALL pushes its offset onto an internal stack, so the
// matching RTN restores the exact previous frame pointer.
//
// Timing of an accepted request sampled in IDLE at cycle n:
//   n+1 MOVE   (FP_move, Ack)
//   n+2 SETTLE (the register file reloads its read window)
//   n+3 IDLE
// A rejected request goes to REJECT at n+1 (Ack, Fault set) and back to IDLE.
//
// Optional feature: define FRAME_HIGHWATER_EN to add the High_Water output,
// which holds the largest frame pointer reached since reset.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   Call_Req, Rtn_Req    decoder requests, held until Ack
//   Call_Offset          CALL advance, legal range 1..7
//   Fault_Clr            clears the sticky Fault
//   New_FP               current frame pointer
//   FP_move              one-cycle pulse: reload the window from New_FP
//   FP_push_up           direction qualifier for FP_move (0 CALL, 1 RTN)
//   Ack                  one-cycle pulse: request accepted or rejected
//   Busy                 high whenever the controller is not idle
//   Fault                sticky error flag
//   Depth                current offset-stack occupancy
//   High_Water           (FRAME_HIGHWATER_EN only) highest FP reached
module frame_pointer_ctrl #(
    parameter int unsigned DEPTH = 16,  // 2..31
    parameter int unsigned FP_W  = 7,
    parameter int unsigned WIN   = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Call_Req,
    input  logic            Rtn_Req,
    input  logic [2:0]      Call_Offset,
    input  logic            Fault_Clr,
    output logic [FP_W-1:0] New_FP,
    output logic            FP_move,
    output logic            FP_push_up,
    output logic            Ack,
    output logic            Busy,
    output logic            Fault,
`ifdef FRAME_HIGHWATER_EN
    output logic [FP_W-1:0] High_Water,
`endif
    output logic [4:0]      Depth
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [FP_W:0] FpMax = (FP_W+1)'((2 ** FP_W) - WIN);

    typedef enum logic [1:0] {StIdle, StMove, StSettle, StReject} state_e;

    state_e          state_q, state_d;
    logic [FP_W-1:0] fp_q, fp_d;
    logic [4:0]      depth_q, depth_d;
    logic            push_up_q, push_up_d;
    logic            fault_q, fault_d;
    logic            push_en;
    logic [2:0]      stack_q [2 ** AW];

    logic [FP_W:0]   call_sum;
    logic [FP_W-1:0] offset_ext;
    logic [FP_W-1:0] top_ext;
    logic            call_ok;
    logic            rtn_ok;

    assign offset_ext = {{(FP_W-3){1'b0}}, Call_Offset};
    assign top_ext    = {{(FP_W-3){1'b0}}, stack_q[AW'(depth_q - 5'd1)]};
    // One extra bit so the overflow compare cannot wrap.
    assign call_sum   = {1'b0, fp_q} + {1'b0, offset_ext};

    assign call_ok = Call_Req && !Rtn_Req && (Call_Offset != 3'd0)
                     && (depth_q < 5'(DEPTH)) && (call_sum <= FpMax);
    assign rtn_ok  = Rtn_Req && !Call_Req && (depth_q != 5'd0);

    always_comb begin
        state_d   = state_q;
        fp_d      = fp_q;
        depth_d   = depth_q;
        push_up_d = push_up_q;
        fault_d   = fault_q;
        push_en   = 1'b0;

        if (Fault_Clr) begin
            fault_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (call_ok) begin
                    state_d   = StMove;
                    fp_d      = fp_q + offset_ext;
                    depth_d   = depth_q + 5'd1;
                    push_en   = 1'b1;
                    push_up_d = 1'b0;
                end else if (rtn_ok) begin
                    state_d   = StMove;
                    fp_d      = fp_q - top_ext;
                    depth_d   = depth_q - 5'd1;
                    push_up_d = 1'b1;
                end else if (Call_Req || Rtn_Req) begin
                    // Setting overrides a simultaneous Fault_Clr.
                    state_d = StReject;
                    fault_d = 1'b1;
                end
            end
            StMove:   state_d = StSettle;
            StSettle: state_d = StIdle;
            StReject: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            fp_q      <= '0;
            depth_q   <= '0;
            push_up_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fp_q      <= fp_d;
            depth_q   <= depth_d;
            push_up_q <= push_up_d;
            fault_q   <= fault_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset here.
    always_ff @(posedge Clock) begin
        if (push_en) begin
            stack_q[AW'(depth_q)] <= Call_Offset;
        end
    end

`ifdef FRAME_HIGHWATER_EN
    logic [FP_W-1:0] hw_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hw_q <= '0;
        end else if ((state_q == StMove) && (fp_q > hw_q)) begin
            hw_q <= fp_q;
        end
    end

    assign High_Water = hw_q;
`endif

    assign New_FP     = fp_q;
    assign FP_move    = (state_q == StMove);
    assign FP_push_up = push_up_q;
    assign Ack        = (state_q == StMove) || (state_q == StReject);
    assign Busy       = (state_q != StIdle);
    assign Fault      = fault_q;
    assign Depth      = depth_q;

endmodule
